// File: rtl/vram_access_arbiter.sv
// vram_access_arbiter: shares single-port VRAM between GPU fetch reads (priority) and windowed CPU writes
// HBLANK_WRITE_EN: when defined, CPU writes also drain during hblank (hcounter 320..399)
module vram_access_arbiter #(
   parameter int FIFO_DEPTH = 8,
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8
) (
   input  logic                          clk_12_5875,
   input  logic                          rst,
   input  logic [9:0]                    hcounter_i,
   input  logic                          writable_i,
   input  logic                          cpu_wr_valid,
   output logic                          cpu_wr_ready,
   input  logic [ADDR_W-1:0]             cpu_wr_addr,
   input  logic [DATA_W-1:0]             cpu_wr_data,
   input  logic                          gpu_rd_req,
   input  logic [ADDR_W-1:0]             gpu_rd_addr,
   output logic                          gpu_rd_valid,
   output logic [DATA_W-1:0]             gpu_rd_data,
   output logic [ADDR_W-1:0]             ram_addr,
   output logic [DATA_W-1:0]             ram_wdata,
   output logic                          ram_we,
   input  logic [DATA_W-1:0]             ram_rdata,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);
   localparam int PW = $clog2(FIFO_DEPTH);
   typedef enum logic [1:0] {IDLE, RD, WR} state_t;
   state_t state;
   logic [ADDR_W+DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic win, push, pop;
`ifdef HBLANK_WRITE_EN
   assign win = writable_i || (hcounter_i >= 10'd320 && hcounter_i <= 10'd399);
`else
   logic unused_hcounter;
   assign unused_hcounter = ^hcounter_i;
   assign win = writable_i;
`endif
   assign cpu_wr_ready = (fifo_count_o != (PW+1)'(FIFO_DEPTH)) && !rst;
   assign push = cpu_wr_valid && cpu_wr_ready;
   // a pending read always steals the slot; the FIFO head simply waits
   assign pop = !gpu_rd_req && fifo_count_o != '0 && win;
   assign gpu_rd_data = ram_rdata;
   always_ff @(posedge clk_12_5875)
      if (push) mem[wr_ptr] <= {cpu_wr_addr, cpu_wr_data};
   always_ff @(posedge clk_12_5875) begin
      if (rst) begin
         state        <= IDLE;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         fifo_count_o <= '0;
         ram_addr     <= '0;
         ram_wdata    <= '0;
         ram_we       <= 1'b0;
         gpu_rd_valid <= 1'b0;
      end else begin
         gpu_rd_valid <= state == RD;
         wr_ptr       <= wr_ptr + PW'(push);
         rd_ptr       <= rd_ptr + PW'(pop);
         fifo_count_o <= fifo_count_o + (PW+1)'(push) - (PW+1)'(pop);
         if (gpu_rd_req) begin
            state    <= RD;
            ram_addr <= gpu_rd_addr;
            ram_we   <= 1'b0;
         end else if (pop) begin
            state                <= WR;
            {ram_addr, ram_wdata} <= mem[rd_ptr];
            ram_we               <= 1'b1;
         end else begin
            state  <= IDLE;
            ram_we <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_vram_access_arbiter.sv
// tb_vram_access_arbiter: directed and random scenarios checked against a queue-based model of the arbiter
module tb_vram_access_arbiter;
   logic clk_12_5875 = 1'b0;
   logic rst = 1'b1;
   logic [9:0] hc = '0;
   logic writable = 1'b0;
   logic cv = 1'b0;
   logic [15:0] ca = '0;
   logic [7:0] cd = '0;
   logic rq = 1'b0;
   logic [15:0] ra = '0;
   logic [7:0] rdata = '0;
   logic cpu_wr_ready, gpu_rd_valid, ram_we;
   logic [7:0] gpu_rd_data, ram_wdata;
   logic [15:0] ram_addr;
   logic [3:0] fifo_count_o;
   int n_cmp = 0;
   int n_err = 0;
   logic [23:0] q[$];
   logic [15:0] e_addr = '0;
   logic [7:0] e_wdata = '0;
   logic e_we = 1'b0;
   logic e_valid = 1'b0;
   logic rd_prev = 1'b0;

   vram_access_arbiter #(.FIFO_DEPTH(8), .ADDR_W(16), .DATA_W(8)) dut (
      .clk_12_5875(clk_12_5875), .rst(rst), .hcounter_i(hc), .writable_i(writable),
      .cpu_wr_valid(cv), .cpu_wr_ready(cpu_wr_ready), .cpu_wr_addr(ca), .cpu_wr_data(cd),
      .gpu_rd_req(rq), .gpu_rd_addr(ra), .gpu_rd_valid(gpu_rd_valid), .gpu_rd_data(gpu_rd_data),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(rdata),
      .fifo_count_o(fifo_count_o)
   );

   always #5 clk_12_5875 = ~clk_12_5875;

   // advance the reference model by one cycle from the current inputs, then clock the DUT
   task automatic step();
      logic w, r;
      w = writable;
`ifdef HBLANK_WRITE_EN
      w = w || (hc >= 10'd320 && hc <= 10'd399);
`endif
      r = !rst && q.size() < 8;
      if (rst) begin
         q.delete();
         e_addr = '0; e_wdata = '0; e_we = 1'b0; e_valid = 1'b0; rd_prev = 1'b0;
      end else begin
         e_valid = rd_prev;
         rd_prev = rq;
         if (rq) begin
            e_addr = ra; e_we = 1'b0;
         end else if (q.size() > 0 && w) begin
            {e_addr, e_wdata} = q.pop_front(); e_we = 1'b1;
         end else e_we = 1'b0;
         if (cv && r) q.push_back({ca, cd});
      end
      @(posedge clk_12_5875);
      #1;
   endtask

   function automatic logic [30:0] obs();
      return {ram_we, ram_addr, ram_wdata, gpu_rd_valid, fifo_count_o, cpu_wr_ready};
   endfunction

   function automatic logic [30:0] expv();
      return {e_we, e_addr, e_wdata, e_valid, 4'(q.size()), !rst && q.size() < 8};
   endfunction

   task automatic test_reset();
      rst = 1'b1; cv = 1'b1; ca = 16'h0bad; cd = 8'hee; writable = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++; if (obs() !== expv()) begin n_err++; $display("FAIL reset: got %h exp %h", obs(), expv()); end
      end
      rst = 1'b0; cv = 1'b0;
   endtask

   task automatic test_single_write();
      writable = 1'b1; cv = 1'b1; ca = 16'h1234; cd = 8'h5a;
      step();
      n_cmp++; if (obs() !== expv()) begin n_err++; $display("FAIL single_accept: got %h exp %h", obs(), expv()); end
      cv = 1'b0;
      step();
      n_cmp++; if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 16'h1234, 8'h5a}) begin
         n_err++; $display("FAIL single_issue: got %b/%h/%h exp 1/1234/5a", ram_we, ram_addr, ram_wdata);
      end
      step();
      n_cmp++; if (obs() !== expv()) begin n_err++; $display("FAIL single_after: got %h exp %h", obs(), expv()); end
   endtask

   task automatic test_window_fill();
      writable = 1'b0; hc = 10'd100;
      for (int i = 0; i < 9; i++) begin
         cv = 1'b1; ca = 16'h0100 + 16'(i); cd = 8'(i + 1);
         step();
         n_cmp++; if (obs() !== expv()) begin n_err++; $display("FAIL fill_%0d: got %h exp %h", i, obs(), expv()); end
      end
      n_cmp++; if ({fifo_count_o, cpu_wr_ready, ram_we} !== {4'd8, 1'b0, 1'b0}) begin
         n_err++; $display("FAIL fill_full: got cnt=%0d rdy=%b we=%b exp cnt=8 rdy=0 we=0", fifo_count_o, cpu_wr_ready, ram_we);
      end
      cv = 1'b0; writable = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
         n_cmp++; if (obs() !== expv()) begin n_err++; $display("FAIL drain_%0d: got %h exp %h", i, obs(), expv()); end
         if (i < 8) begin
            n_cmp++; if ({ram_we, ram_addr} !== {1'b1, 16'h0100 + 16'(i)}) begin
               n_err++; $display("FAIL drain_order_%0d: got %b/%h exp 1/%h", i, ram_we, ram_addr, 16'h0100 + 16'(i));
            end
         end
      end
   endtask

   task automatic test_read_priority();
      writable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cv = 1'b1; ca = 16'h0200 + 16'(i); cd = 8'h30 + 8'(i);
         step();
      end
      cv = 1'b0; writable = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rq = i < 2; ra = 16'ha000 + 16'(i);
         step();
         n_cmp++; if (obs() !== expv()) begin n_err++; $display("FAIL rd_prio_%0d: got %h exp %h", i, obs(), expv()); end
      end
      rq = 1'b0;
   endtask

   task automatic test_reset_mid_drain();
      writable = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cv = 1'b1; ca = 16'h0300 + 16'(i); cd = 8'(i);
         step();
      end
      cv = 1'b0; writable = 1'b1;
      step();
      rst = 1'b1;
      step();
      n_cmp++; if ({ram_we, fifo_count_o} !== {1'b0, 4'd0}) begin
         n_err++; $display("FAIL rst_mid: got we=%b cnt=%0d exp we=0 cnt=0", ram_we, fifo_count_o);
      end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_cmp++; if (obs() !== expv()) begin n_err++; $display("FAIL rst_after_%0d: got %h exp %h", i, obs(), expv()); end
      end
   endtask

   task automatic test_hblank();
      logic want;
`ifdef HBLANK_WRITE_EN
      want = 1'b1;
`else
      want = 1'b0;
`endif
      writable = 1'b0; hc = 10'd100;
      for (int i = 0; i < 2; i++) begin
         cv = 1'b1; ca = 16'h0400 + 16'(i); cd = 8'h77;
         step();
      end
      cv = 1'b0; hc = 10'd319;
      step();
      n_cmp++; if (ram_we !== 1'b0) begin n_err++; $display("FAIL hblank_319: got we=%b exp 0", ram_we); end
      hc = 10'd320;
      step();
      n_cmp++; if (ram_we !== want) begin n_err++; $display("FAIL hblank_320: got we=%b exp %b", ram_we, want); end
      for (int i = 0; i < 3; i++) begin
         hc = 10'd321 + 10'(i);
         step();
         n_cmp++; if (obs() !== expv()) begin n_err++; $display("FAIL hblank_%0d: got %h exp %h", i, obs(), expv()); end
      end
      hc = 10'd100; writable = 1'b1;
      for (int i = 0; i < 3; i++) step();
   endtask

   task automatic test_full_push_pop();
      writable = 1'b0; hc = 10'd100;
      for (int i = 0; i < 8; i++) begin
         cv = 1'b1; ca = 16'h0500 + 16'(i); cd = 8'(8'h80 + i);
         step();
      end
      ca = 16'hdead; cd = 8'hff; writable = 1'b1;
      step();
      n_cmp++; if ({fifo_count_o, cpu_wr_ready, ram_we, ram_addr} !== {4'd7, 1'b1, 1'b1, 16'h0500}) begin
         n_err++; $display("FAIL full_pushpop: got cnt=%0d rdy=%b we=%b a=%h exp 7/1/1/0500", fifo_count_o, cpu_wr_ready, ram_we, ram_addr);
      end
      cv = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         n_cmp++; if (obs() !== expv()) begin n_err++; $display("FAIL full_drain_%0d: got %h exp %h", i, obs(), expv()); end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rst = $urandom_range(0, 99) == 0;
         rq = $urandom_range(0, 9) < 3;
         ra = 16'($urandom);
         cv = $urandom_range(0, 1);
         ca = 16'($urandom);
         cd = 8'($urandom);
         rdata = 8'($urandom);
         if ($urandom_range(0, 15) == 0) writable = ~writable;
         hc = 10'($urandom_range(280, 399));
         n_cmp++; if (gpu_rd_data !== rdata) begin n_err++; $display("FAIL rand_rdata_%0d: got %h exp %h", i, gpu_rd_data, rdata); end
         step();
         n_cmp++; if (obs() !== expv()) begin n_err++; $display("FAIL rand_%0d: got %h exp %h", i, obs(), expv()); end
      end
      rst = 1'b0; rq = 1'b0; cv = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_window_fill();
      test_read_priority();
      test_reset_mid_drain();
      test_hblank();
      test_full_push_pop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
